// File: rtl/period_meter_if.sv
// Bundle between the wheel-sensor front end and the period meter:
// enable and sensor level in, measurement results out.
interface period_meter_if #(
  parameter int CNT_W = 24
);
  logic             en;
  logic             pulse_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stopped;
  logic [15:0]      rev_cnt;

  modport master (
    output en,
    output pulse_in,
    input  period,
    input  period_valid,
    input  stopped,
    input  rev_cnt
  );

  modport slave (
    input  en,
    input  pulse_in,
    output period,
    output period_valid,
    output stopped,
    output rev_cnt
  );
endinterface

// File: rtl/period_meter_ctrl.sv
// Period meter for the velocimeter: detects rising edges of the debounced
// wheel signal, measures the cycle distance between accepted edges with a
// single counter, rejects glitch edges closer than MIN_PERIOD, declares the
// wheel stopped after TIMEOUT cycles without an edge and counts revolutions.
module period_meter_ctrl #(
  parameter int CNT_W      = 24,
  parameter int TIMEOUT    = 10000000,
  parameter int MIN_PERIOD = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  state_t           state_p0, state_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;
  logic [CNT_W-1:0] period_p0, period_d;
  logic             vld_p0, vld_d;
  logic             stopped_p0, stopped_d;
  logic [15:0]      rev_cnt_p0, rev_cnt_d;
  logic             prev_p0;
  logic             rise;

  // Counter advance clamped at TIMEOUT so the count can never run past it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= TIMEOUT_C) return TIMEOUT_C;
    else                return v + ONE_C;
  endfunction

  assign rise = bus.pulse_in & ~prev_p0;

  // Next-state and measurement decisions; en low overrides everything.
  always_comb begin
    state_d   = state_p0;
    cnt_d     = cnt_p0;
    period_d  = period_p0;
    vld_d     = 1'b0;
    stopped_d = stopped_p0;
    rev_cnt_d = rev_cnt_p0;
    if (!bus.en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      stopped_d = 1'b1;
    end else begin
      case (state_p0)
        IDLE: begin
          cnt_d   = '0;
          state_d = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (rise) begin
            cnt_d     = ONE_C;
            rev_cnt_d = rev_cnt_p0 + 16'd1;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          if (rise && (cnt_p0 >= MIN_C)) begin
            // Accepted edge closes the period, even when it lands on TIMEOUT.
            period_d  = cnt_p0;
            vld_d     = 1'b1;
            stopped_d = 1'b0;
            rev_cnt_d = rev_cnt_p0 + 16'd1;
            cnt_d     = ONE_C;
          end else if (rise) begin
            // Residual glitch: keep counting as if it never happened.
            cnt_d = sat_inc(cnt_p0);
          end else if (cnt_p0 == TIMEOUT_C) begin
            period_d  = '0;
            vld_d     = 1'b1;
            stopped_d = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_FIRST;
          end else begin
            cnt_d = sat_inc(cnt_p0);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage p0: state, counter, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0   <= IDLE;
      cnt_p0     <= '0;
      period_p0  <= '0;
      vld_p0     <= 1'b0;
      stopped_p0 <= 1'b1;
      rev_cnt_p0 <= '0;
      prev_p0    <= 1'b0;
    end else begin
      state_p0   <= state_d;
      cnt_p0     <= cnt_d;
      period_p0  <= period_d;
      vld_p0     <= vld_d;
      stopped_p0 <= stopped_d;
      rev_cnt_p0 <= rev_cnt_d;
      prev_p0    <= bus.pulse_in;
    end
  end

  assign bus.period       = period_p0;
  assign bus.period_valid = vld_p0;
  assign bus.stopped      = stopped_p0;
  assign bus.rev_cnt      = rev_cnt_p0;

endmodule
